// File: rtl/chip8_video_mux.sv
// rtl/chip8_video_mux.sv - CHIP-8 VRAM-to-HDMI pixel pipeline with lores/hires and 2x2 grid views
module chip8_video_mux #(
    parameter int NUM_CH = 1,
    parameter int RD_LAT = 2,
    parameter int H_OFF  = 128,
    parameter int V_OFF  = 104
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 active_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 grid_en_in,
    input  logic [1:0]           sel_in,
    input  logic [NUM_CH-1:0]    hires_in,
    output logic [10*NUM_CH-1:0] vram_addr_out,
    input  logic [8*NUM_CH-1:0]  vram_data_in,
    output logic [1:0]           pixel_out,
    output logic [1:0]           pixel_ch_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 active_out
);
    typedef struct packed {
        logic       border;
        logic [1:0] ch;
        logic [2:0] bidx;
        logic       act;
        logic       hs;
        logic       vs;
    } side_t;

    logic              grid_q, grid_d;
    logic [1:0]        sel_q, sel_d;
    logic [NUM_CH-1:0] hires_q, hires_d;
    logic              frame_start;

    // The (0,0) cycle bypasses the latch so a mode change there applies to the new frame
    always_comb begin
        frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        grid_d      = grid_q;
        sel_d       = sel_q;
        hires_d     = hires_q;
        if (frame_start) begin
            grid_d  = grid_en_in;
            sel_d   = (32'(sel_in) < NUM_CH) ? sel_in : 2'd0;
            hires_d = hires_in;
        end
    end

    logic [12:0]          dx;
    logic [11:0]          dy;
    logic                 in_win;
    logic                 empty;
    logic                 border;
    logic [1:0]           quad;
    logic [1:0]           core;
    logic [9:0]           lx;
    logic [8:0]           ly;
    logic [3:0]           hires_pad;
    logic [2:0]           s_k;
    logic [9:0]           px_k;
    logic [8:0]           py_k;
    logic [2:0]           s_disp;
    logic [9:0]           px_disp;
    logic [10*NUM_CH-1:0] addr_d;
    side_t                sb_d;

    always_comb begin
        dx        = {2'b00, hcount_in} - 13'(H_OFF);
        dy        = {2'b00, vcount_in} - 12'(V_OFF);
        in_win    = (dx[12:10] == 3'd0) && (dy[11:9] == 3'd0);
        quad      = {dy[8], dx[9]};
        core      = grid_d ? quad : sel_d;
        empty     = grid_d && (32'(quad) >= NUM_CH);
        border    = !in_win || empty;
        lx        = grid_d ? {1'b0, dx[8:0]} : dx[9:0];
        ly        = grid_d ? {1'b0, dy[7:0]} : dy[8:0];
        hires_pad = 4'(hires_d);

        addr_d = '0;
        s_k    = 3'd0;
        px_k   = '0;
        py_k   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s_k  = 3'd4 - {2'b00, hires_d[k]} - {2'b00, grid_d};
            px_k = lx >> s_k;
            py_k = ly >> s_k;
            if (in_win)
                addr_d[10*k +: 10] = hires_d[k] ? {py_k[5:0], px_k[6:3]}
                                                : {2'b00, py_k[4:0], px_k[5:3]};
        end

        s_disp      = 3'd4 - {2'b00, hires_pad[core]} - {2'b00, grid_d};
        px_disp     = lx >> s_disp;
        sb_d.border = border;
        sb_d.ch     = border ? 2'd0 : core;
        sb_d.bidx   = px_disp[2:0];
        sb_d.act    = active_in;
        sb_d.hs     = hsync_in;
        sb_d.vs     = vsync_in;
    end

    side_t                sb_q [RD_LAT+1];
    logic [10*NUM_CH-1:0] addr_q;
    logic [1:0]           pix_q, ch_q;
    logic                 hs_q, vs_q, act_q;
    logic [31:0]          data_pad;
    logic [7:0]           byte_sel;

    always_comb begin
        data_pad = 32'(vram_data_in);
        byte_sel = data_pad[{sb_q[RD_LAT].ch, 3'b000} +: 8];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grid_q  <= 1'b0;
            sel_q   <= 2'd0;
            hires_q <= '0;
            addr_q  <= '0;
            for (int i = 0; i <= RD_LAT; i++) sb_q[i] <= '0;
            pix_q   <= 2'd3;
            ch_q    <= 2'd0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            grid_q  <= grid_d;
            sel_q   <= sel_d;
            hires_q <= hires_d;
            addr_q  <= addr_d;
            sb_q[0] <= sb_d;
            for (int i = 1; i <= RD_LAT; i++) sb_q[i] <= sb_q[i-1];
            hs_q    <= sb_q[RD_LAT].hs;
            vs_q    <= sb_q[RD_LAT].vs;
            act_q   <= sb_q[RD_LAT].act;
            if (!sb_q[RD_LAT].act) begin
                pix_q <= 2'd3;
                ch_q  <= 2'd0;
            end else if (sb_q[RD_LAT].border) begin
                pix_q <= 2'd2;
                ch_q  <= 2'd0;
            end else begin
                pix_q <= {1'b0, byte_sel[sb_q[RD_LAT].bidx]};
                ch_q  <= sb_q[RD_LAT].ch;
            end
        end
    end

    assign vram_addr_out = addr_q;
    assign pixel_out     = pix_q;
    assign pixel_ch_out  = ch_q;
    assign hsync_out     = hs_q;
    assign vsync_out     = vs_q;
    assign active_out    = act_q;
endmodule
